// File: rtl/multi_one_shot.sv
// Multi-channel clocked one-shot: synchronises hit inputs and emits start/stop pulses of programmable width with a dead time.
// Optional per-channel ignored-rise counters are enabled by defining MULTI_ONE_SHOT_MISS_CNT_EN.
module multi_one_shot #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   pulse_in,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic              miss_clr,
    output logic [N_CH-1:0]   start,
    output logic [N_CH-1:0]   stop,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   miss
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
    ,
    output logic [N_CH*8-1:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        HIGH,
        STOP,
        DEAD
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES:0] valid_q;
    logic [CNT_W-1:0]     widthLoad_d;
    logic [CNT_W-1:0]     holdoffLoad_d;

    assign widthLoad_d   = (width == '0) ? '0 : width - ONE;
    assign holdoffLoad_d = holdoff - ONE;

    // Gates edge detection until prev holds a genuine sample, so an input
    // already high at reset release must first be seen low before it can rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : gChan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        state_t                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   start_q;
        logic                   stop_q;
        logic                   busy_q;
        logic                   miss_q;
        logic                   rise_d;
        logic                   fall_d;
        logic                   missSet_d;

        assign rise_d    = sync_q[SYNC_STAGES-1] & ~prev_q & valid_q[SYNC_STAGES];
        assign fall_d    = ~sync_q[SYNC_STAGES-1] & prev_q;
        assign missSet_d = rise_d & ((state_q == STOP) || (state_q == DEAD));

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in[ch]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        // Outputs are registered alongside each state change so they never glitch.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                start_q <= 1'b0;
                stop_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise_d) begin
                            state_q <= START;
                            cnt_q   <= widthLoad_d;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (fall_d) begin
                            state_q <= STOP;
                            cnt_q   <= widthLoad_d;
                            start_q <= 1'b0;
                            stop_q  <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q <= HIGH;
                            start_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    HIGH: begin
                        if (fall_d) begin
                            state_q <= STOP;
                            cnt_q   <= widthLoad_d;
                            stop_q  <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt_q == '0) begin
                            stop_q <= 1'b0;
                            if (holdoff == '0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DEAD;
                                cnt_q   <= holdoffLoad_d;
                            end
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    DEAD: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        start_q <= 1'b0;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        // A new miss in the same cycle as a clear must survive.
        always_ff @(posedge clk) begin
            if (rst) begin
                miss_q <= 1'b0;
            end else if (missSet_d) begin
                miss_q <= 1'b1;
            end else if (miss_clr) begin
                miss_q <= 1'b0;
            end
        end

        assign start[ch] = start_q;
        assign stop[ch]  = stop_q;
        assign busy[ch]  = busy_q;
        assign miss[ch]  = miss_q;

`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        logic [7:0] missCnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                missCnt_q <= '0;
            end else if (missSet_d) begin
                if (miss_clr) begin
                    missCnt_q <= 8'd1;
                end else if (missCnt_q != 8'hFF) begin
                    missCnt_q <= missCnt_q + 8'd1;
                end
            end else if (miss_clr) begin
                missCnt_q <= '0;
            end
        end

        assign miss_cnt[ch*8 +: 8] = missCnt_q;
`endif
    end

endmodule

// File: tb/tb_multi_one_shot.sv
// Self-checking bench for multi_one_shot: table-driven pulse vectors with a scoreboard queue plus
// hand-written miss, reset and saturation sequences (counter checks need MULTI_ONE_SHOT_MISS_CNT_EN).
module tb_multi_one_shot;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pulseIn;
    logic [7:0]  widthIn;
    logic [7:0]  holdoffIn;
    logic        missClr;
    logic [3:0]  startOut;
    logic [3:0]  stopOut;
    logic [3:0]  busyOut;
    logic [3:0]  missOut;
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
    logic [31:0] missCntOut;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         w;
        int         h;
        int         highCycles;
        logic [3:0] mask;
        int         expStartFirst;
        int         expStartLen;
        int         expStopFirst;
        int         expStopLen;
        int         expBusyLen;
    } vec_t;

    vec_t vecs[8];
    vec_t expQ[$];

    int stFirst[4];
    int stLen[4];
    int spFirst[4];
    int spLen[4];
    int bsLen[4];
    int overlap;
    int timedOut;

    multi_one_shot #(
        .N_CH(4),
        .CNT_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulseIn),
        .width(widthIn),
        .holdoff(holdoffIn),
        .miss_clr(missClr),
        .start(startOut),
        .stop(stopOut),
        .busy(busyOut),
        .miss(missOut)
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        ,
        .miss_cnt(missCntOut)
`endif
    );

    always #5 clk = ~clk;

    // Last-resort guard in case a wait escapes its cycle budget.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drives one pulse on the masked channels and records per-channel timing, relative to the first sampling edge.
    task automatic applyStimulus(input vec_t v);
        bit done;
        @(negedge clk);
        widthIn   = 8'(v.w);
        holdoffIn = 8'(v.h);
        pulseIn   = v.mask;
        expQ.push_back(v);
        for (int c = 0; c < 4; c++) begin
            stFirst[c] = 0; stLen[c] = 0; spFirst[c] = 0; spLen[c] = 0; bsLen[c] = 0;
        end
        overlap  = 0;
        timedOut = 1;
        done     = 0;
        for (int t = 1; t <= 2000 && !done; t++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (startOut[c]) begin
                    if (stFirst[c] == 0) stFirst[c] = t;
                    stLen[c]++;
                end
                if (stopOut[c]) begin
                    if (spFirst[c] == 0) spFirst[c] = t;
                    spLen[c]++;
                end
                if (busyOut[c]) bsLen[c]++;
            end
            if ((startOut & stopOut) != 4'b0) overlap++;
            if (t == v.highCycles) pulseIn = 4'b0;
            if (t > 3 && busyOut == 4'b0 && pulseIn == 4'b0) begin
                done     = 1;
                timedOut = 0;
            end
        end
        pulseIn = 4'b0;
    endtask

    task automatic scoreVector(input int idx);
        vec_t e;
        string tag;
        e = expQ.pop_front();
        checkOutput($sformatf("v%0d timeout", idx), timedOut, 0);
        checkOutput($sformatf("v%0d overlap", idx), overlap, 0);
        for (int c = 0; c < 4; c++) begin
            tag = $sformatf("v%0d ch%0d", idx, c);
            if (e.mask[c]) begin
                checkOutput({tag, " startFirst"}, stFirst[c], e.expStartFirst);
                checkOutput({tag, " startLen"},   stLen[c],   e.expStartLen);
                checkOutput({tag, " stopFirst"},  spFirst[c], e.expStopFirst);
                checkOutput({tag, " stopLen"},    spLen[c],   e.expStopLen);
                checkOutput({tag, " busyLen"},    bsLen[c],   e.expBusyLen);
            end else begin
                checkOutput({tag, " idleBusy"}, bsLen[c], 0);
            end
        end
    endtask

    task automatic waitIdle(input logic [3:0] mask, input string name);
        int n;
        n = 0;
        while ((busyOut & mask) != 4'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idleTimeout"}, int'((busyOut & mask) != 4'b0), 0);
    endtask

    initial begin
        int seen;
        int firstT;
        // {w, h, highCycles, mask, startFirst, startLen, stopFirst, stopLen, busyLen}
        vecs[0] = '{4,   0, 20,  4'b0001, 3, 4,   23,  4,   24};
        vecs[1] = '{10,  0, 3,   4'b0001, 3, 3,   6,   10,  13};
        vecs[2] = '{0,   5, 4,   4'b0001, 3, 1,   7,   1,   10};
        vecs[3] = '{2,   3, 6,   4'b1111, 3, 2,   9,   2,   11};
        vecs[4] = '{5,   1, 2,   4'b1111, 3, 2,   5,   5,   8};
        vecs[5] = '{7,   0, 7,   4'b1111, 3, 7,   10,  7,   14};
        vecs[6] = '{255, 0, 260, 4'b0010, 3, 255, 263, 255, 515};
        vecs[7] = '{1,   2, 1,   4'b1000, 3, 1,   4,   1,   4};

        rst = 1'b1; pulseIn = 4'b0; widthIn = 8'd4; holdoffIn = 8'd0; missClr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset start", int'(startOut), 0);
        checkOutput("reset stop",  int'(stopOut),  0);
        checkOutput("reset busy",  int'(busyOut),  0);
        checkOutput("reset miss",  int'(missOut),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            scoreVector(i);
            repeat (4) @(negedge clk);
        end

        // Rise during DEAD must be ignored and flagged.
        @(negedge clk);
        widthIn = 8'd0; holdoffIn = 8'd20;
        pulseIn[0] = 1'b1;
        repeat (2) @(negedge clk);
        pulseIn[0] = 1'b0;
        repeat (6) @(negedge clk);
        pulseIn[0] = 1'b1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 2) pulseIn[0] = 1'b0;
            if (startOut[0]) seen++;
        end
        checkOutput("dead noStart", seen, 0);
        checkOutput("dead miss",    int'(missOut[0]), 1);
        checkOutput("dead busy",    int'(busyOut[0]), 1);
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        checkOutput("dead missCnt", int'(missCntOut[7:0]), 1);
`endif
        waitIdle(4'b0001, "dead");
        missClr = 1'b1;
        @(negedge clk);
        missClr = 1'b0;
        checkOutput("missClr miss", int'(missOut[0]), 0);
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        checkOutput("missClr missCnt", int'(missCntOut[7:0]), 0);
`endif

        // Set and clear in the same cycle: set wins.
        widthIn = 8'd0; holdoffIn = 8'd40;
        pulseIn[1] = 1'b1;
        repeat (2) @(negedge clk);
        pulseIn[1] = 1'b0;
        repeat (6) @(negedge clk);
        pulseIn[1] = 1'b1;
        repeat (2) @(negedge clk);
        pulseIn[1] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("setClr preMiss", int'(missOut[1]), 1);
        pulseIn[1] = 1'b1;
        repeat (2) @(negedge clk);
        missClr = 1'b1;
        @(negedge clk);
        missClr = 1'b0;
        pulseIn[1] = 1'b0;
        checkOutput("setClr miss", int'(missOut[1]), 1);
`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        checkOutput("setClr missCnt", int'(missCntOut[15:8]), 1);
`endif
        waitIdle(4'b0010, "setClr");

        // Reset mid-START, then an input held high must not re-trigger.
        widthIn = 8'd10; holdoffIn = 8'd0;
        pulseIn[2] = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rstSeq startBefore", int'(startOut[2]), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstSeq start", int'(startOut), 0);
        checkOutput("rstSeq stop",  int'(stopOut),  0);
        checkOutput("rstSeq busy",  int'(busyOut),  0);
        checkOutput("rstSeq miss",  int'(missOut),  0);
        rst = 1'b0;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (startOut[2] || busyOut[2]) seen++;
        end
        checkOutput("rstSeq heldHigh", seen, 0);
        pulseIn[2] = 1'b0;
        seen = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (stopOut[2] || busyOut[2]) seen++;
        end
        checkOutput("rstSeq idleFall", seen, 0);
        pulseIn[2] = 1'b1;
        firstT = 0;
        for (int t = 1; t <= 10 && firstT == 0; t++) begin
            @(negedge clk);
            if (startOut[2]) firstT = t;
        end
        checkOutput("rstSeq reArm", firstT, 3);
        pulseIn[2] = 1'b0;
        waitIdle(4'b0100, "rstSeq");

`ifdef MULTI_ONE_SHOT_MISS_CNT_EN
        // Fast toggling through long dead times saturates the counter.
        widthIn = 8'd0; holdoffIn = 8'd255;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pulseIn[3] = 1'b1;
            @(negedge clk);
            pulseIn[3] = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkOutput("sat missCnt", int'(missCntOut[31:24]), 255);
        checkOutput("sat miss",    int'(missOut[3]), 1);
        waitIdle(4'b1000, "sat");
        missClr = 1'b1;
        @(negedge clk);
        missClr = 1'b0;
        checkOutput("sat cleared", int'(missCntOut[31:24]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_one_shot.md
Name: multi_one_shot

Overview:
- Clocked, multi-channel successor to the carry-chain one-shot in the TDC front end.
- Per channel: synchronises an asynchronous hit input, detects its rising and falling edges, and emits start/stop pulses of programmable width in clock cycles.
- After each stop, a programmable dead time runs and re-arming is blocked; edges arriving while not armed are flagged.
- Sits between the hit inputs and the TDC capture / coarse-counter logic.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 8, width of the pulse-width and holdoff counters and their config inputs.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pulse_in  input  N_CH  asynchronous hit inputs, one bit per channel.
- width  input  CNT_W  start/stop pulse length in cycles, shared by all channels.
- holdoff  input  CNT_W  dead-time cycles after each stop pulse, shared by all channels.
- miss_clr  input  1  single-cycle clear of all miss flags.
- start  output  N_CH  start pulse, one bit per channel.
- stop  output  N_CH  stop pulse, one bit per channel.
- busy  output  N_CH  high whenever the channel FSM is not in IDLE.
- miss  output  N_CH  sticky flag: an edge was ignored.

Behaviour:
- Reset: while rst is high at a clock edge:
  - all synchroniser and previous-value flops clear to 0;
  - every FSM goes to IDLE;
  - start, stop, busy and miss are all 0.
- Reset mid-pulse truncates the pulse on the next edge.
- After reset deassertion, an input already high gives no rise until it has been seen low.
- Synchroniser: chain of SYNC_STAGES flops, then a prev flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Latency: an input change sampled at edge k drives start/stop high after edge k+SYNC_STAGES (3 edges total for default 2 stages).
- Width: W = (width==0) ? 1 : width.
  - width is sampled when START or STOP is entered; changes mid-pulse are ignored.
- Holdoff: H = holdoff, sampled on entry to DEAD; 0 means DEAD is skipped.
- All outputs are registered and driven directly from the FSM state.
- Per-channel FSM: IDLE, START, HIGH, STOP, DEAD.
  - IDLE: rise -> START, load counter with W-1. A fall in IDLE is ignored, without setting miss.
  - START (start=1): fall -> STOP with counter reloaded. This truncates start, matching the original combinational one-shot where start drops with the input. Otherwise, when the counter reaches 0 -> HIGH; else decrement.
  - HIGH: fall -> STOP, load W-1.
  - STOP (stop=1): when the counter reaches 0 -> DEAD, loading H-1 (or straight to IDLE if H=0). A rise in STOP sets miss.
  - DEAD: when the counter reaches 0 -> IDLE. A rise in DEAD sets miss and does not re-arm.
- start and stop are never high together on one channel.
- Channels are fully independent; simultaneous edges on multiple channels are all serviced in the same cycle.
- miss:
  - set on an ignored rise; clears only on rst or miss_clr;
  - if set and clear coincide in the same cycle, set wins.
- Counter width is CNT_W with no wrap. The maximum W of 2^CNT_W-1 must produce exactly that many cycles.

Optional Feature:
- Macro: MULTI_ONE_SHOT_MISS_CNT_EN.
- Defined:
  - adds output miss_cnt, width N_CH*8: per-channel 8-bit count of ignored rises;
  - saturates at 255;
  - cleared by rst and miss_clr; set-beats-clear applies, so the count becomes 1.
- Undefined: miss_cnt port and counters are absent; the miss flag alone remains.

Test Plan:
- Reset, then width=4, holdoff=0, ch0 input high for 20 cycles -> start[0] high for exactly 4 cycles, beginning 3 edges after the rise; stop[0] high for 4 cycles beginning 3 edges after the fall; busy[0] spans both.
- width=10, input high for only 3 cycles -> start is truncated; stop follows immediately; start and stop are never high together.
- width=0, holdoff=5 -> 1-cycle start, 1-cycle stop, busy held 5 more cycles. A rise during DEAD gives no start and sets miss; miss_clr then clears it.
- All 4 channels toggled in the same cycle with staggered widths on re-runs -> identical independent pulse timing on every channel.
- Assert rst during START -> all outputs 0 on the next edge. With the input still high after release, there is no start until the input goes low then high.
- With MULTI_ONE_SHOT_MISS_CNT_EN, 300 rises during a long holdoff (holdoff=255, fast toggling) -> miss_cnt saturates at 255; miss_clr asserted together with a miss event -> count = 1.
